// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM BIST initiator.
// March phases, default geometry and address-walk directions.
`timescale 1ns/1ps
package ram_bist_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 6;

    localparam logic ASC  = 1'b0;
    localparam logic DESC = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1R,
        M1W,
        M2R,
        M2W,
        M3,
        DRAIN,
        DONE
    } state_t;

    function automatic logic is_read(state_t s);
        return (s == M1R) || (s == M2R) || (s == M3);
    endfunction

endpackage

// File: rtl/ram_bist_checker.sv
// One-cycle compare pipeline with first-failure capture.
// A read issued in cycle N is compared against ram_q at the end of N+1.
`timescale 1ns/1ps
module ram_bist_checker
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [DATA_W-1:0] ram_q,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    logic              pend_v;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_exp;
    logic              miss;

    assign miss = pend_v && (ram_q != pend_exp);

    // Hold the issued read for one cycle until its data returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_exp  <= '0;
        end else begin
            pend_v    <= rd_valid && !clr;
            pend_addr <= rd_addr;
            pend_exp  <= rd_exp;
        end
    end

    // Latch only the first mismatch; later ones leave the record alone.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (miss && !fail) begin
            fail      <= 1'b1;
            fail_addr <= pend_addr;
            fail_exp  <= pend_exp;
            fail_got  <= ram_q;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-style BIST initiator for the single-port RAM.
// Sequence: up(W P), up(R P, W ~P), down(R ~P, W P), up(R P).
`timescale 1ns/1ps
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bg,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_step;
    logic [DATA_W-1:0] p_q;
    logic [DATA_W-1:0] p_d;
    logic              dir;
    logic              clr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_exp;

    // State, address counter and captured background.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            p_q     <= p_d;
        end
    end

    assign addr_step = (dir == DESC) ? (addr_q - ONE) : (addr_q + ONE);

    // Next state, address walk and RAM drive for each March phase.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        p_d      = p_q;
        dir      = ASC;
        clr      = 1'b0;
        ram_we   = 1'b0;
        ram_data = '0;
        rd_exp   = p_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = M0;
                    addr_d  = '0;
                    p_d     = bg;
                    clr     = 1'b1;
                end
            end
            M0: begin
                ram_we   = 1'b1;
                ram_data = p_q;
                addr_d   = addr_step;
                if (addr_q == LAST) state_d = M1R;
            end
            M1R: begin
                rd_exp  = p_q;
                state_d = M1W;
            end
            M1W: begin
                ram_we   = 1'b1;
                ram_data = ~p_q;
                addr_d   = addr_step;
                state_d  = M1R;
                if (addr_q == LAST) begin
                    state_d = M2R;
                    addr_d  = LAST;
                end
            end
            M2R: begin
                rd_exp  = ~p_q;
                state_d = M2W;
            end
            M2W: begin
                dir      = DESC;
                ram_we   = 1'b1;
                ram_data = p_q;
                addr_d   = addr_step;
                state_d  = M2R;
                if (addr_q == '0) begin
                    state_d = M3;
                    addr_d  = '0;
                end
            end
            M3: begin
                rd_exp = p_q;
                addr_d = addr_step;
                if (addr_q == LAST) begin
                    state_d = DRAIN;
                    addr_d  = addr_q;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign rd_valid = is_read(state_q);
    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);

    ram_bist_checker #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .rd_valid (rd_valid),
        .rd_addr  (addr_q),
        .rd_exp   (rd_exp),
        .ram_q    (ram_q),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural 64x8 RAM.
// Fault modes corrupt read data to exercise the failure capture.
`timescale 1ns/1ps
module tb_ram_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bg;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;
    logic       busy;
    logic       done;
    logic       fail;
    logic [5:0] fail_addr;
    logic [7:0] fail_exp;
    logic [7:0] fail_got;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [64];
    logic [5:0] ar;
    logic       flip5;
    logic       stuck63;
    int         wr_cnt;
    int         nw_cnt;

    ram_bist_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bg       (bg),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_q    (ram_q),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write at the edge, registered address, 1-cycle read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ar <= ram_addr;
    end

    always_comb begin
        ram_q = mem[ar];
        if (flip5 && ar == 6'd5) ram_q = ram_q ^ 8'h08;
        if (stuck63 && ar == 6'd63) ram_q[0] = 1'b1;
    end

    always @(negedge clk) begin
        if (busy) begin
            if (ram_we) wr_cnt++;
            else nw_cnt++;
        end
    end

    task automatic start_pulse(input logic [7:0] pat);
        @(negedge clk);
        wr_cnt = 0;
        nw_cnt = 0;
        bg     = pat;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        bg    = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, fail, ram_we} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {busy, done, fail, ram_we});
        end
        checks++;
        if ({fail_addr, fail_exp, fail_got, ram_addr, ram_data} !== 36'd0) begin
            errors++;
            $display("FAIL reset_buses got=%h exp=0",
                     {fail_addr, fail_exp, fail_got, ram_addr, ram_data});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_pass();
        int n;
        start_pulse(8'h55);
        wait_done(n);
        checks++;
        if (n != 385) begin
            errors++;
            $display("FAIL clean_busy got=%0d exp=385", n);
        end
        checks++;
        if ({done, fail} !== 2'b10) begin
            errors++;
            $display("FAIL clean_done_fail got=%b exp=10", {done, fail});
        end
        checks++;
        if (wr_cnt != 192) begin
            errors++;
            $display("FAIL clean_writes got=%0d exp=192", wr_cnt);
        end
        checks++;
        if (nw_cnt != 193) begin
            errors++;
            $display("FAIL clean_nonwrite got=%0d exp=193", nw_cnt);
        end
        checks++;
        if (mem[0] !== 8'h55 || mem[37] !== 8'h55 || mem[63] !== 8'h55) begin
            errors++;
            $display("FAIL clean_mem got=%h/%h/%h exp=55",
                     mem[0], mem[37], mem[63]);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ram_we} !== 3'b010) begin
            errors++;
            $display("FAIL done_hold got=%b exp=010", {busy, done, ram_we});
        end
    endtask

    task automatic test_stuck_bit();
        int n;
        flip5 = 1'b1;
        start_pulse(8'h55);
        wait_done(n);
        flip5 = 1'b0;
        checks++;
        if (n != 385 || done !== 1'b1) begin
            errors++;
            $display("FAIL stuck_done got=%0d/%b exp=385/1", n, done);
        end
        checks++;
        if ({fail, fail_addr, fail_exp, fail_got} !== {1'b1, 6'd5, 8'h55, 8'h5D}) begin
            errors++;
            $display("FAIL stuck_rec got=%b %0d %h %h exp=1 5 55 5d",
                     fail, fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_restart();
        int n;
        start_pulse(8'hA5);
        checks++;
        if ({busy, done, fail, fail_addr, fail_exp, fail_got} !== {2'b10, 23'd0}) begin
            errors++;
            $display("FAIL restart_clear got=%b%b%b %0d %h %h exp=100 0 00 00",
                     busy, done, fail, fail_addr, fail_exp, fail_got);
        end
        wait_done(n);
        checks++;
        if (n != 385 || {done, fail} !== 2'b10) begin
            errors++;
            $display("FAIL restart_pass got=%0d %b exp=385 10", n, {done, fail});
        end
    endtask

    task automatic test_second_phase();
        int n;
        stuck63 = 1'b1;
        start_pulse(8'hFF);
        wait_done(n);
        stuck63 = 1'b0;
        checks++;
        if ({fail, fail_addr, fail_exp, fail_got} !== {1'b1, 6'd63, 8'h00, 8'h01}) begin
            errors++;
            $display("FAIL phase2_rec got=%b %0d %h %h exp=1 63 00 01",
                     fail, fail_addr, fail_exp, fail_got);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int we_seen;
        start_pulse(8'h55);
        n = 1;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, fail, ram_we, ram_addr, ram_data} !== 18'd0) begin
            errors++;
            $display("FAIL midrst_out got=%b%b%b%b %0d %h exp=0000 0 00",
                     busy, done, fail, ram_we, ram_addr, ram_data);
        end
        we_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ram_we) we_seen++;
        end
        checks++;
        if (we_seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet got=%0d/%b exp=0/0", we_seen, busy);
        end
        start_pulse(8'h55);
        wait_done(n);
        checks++;
        if (n != 385 || {done, fail} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_rerun got=%0d %b exp=385 10", n, {done, fail});
        end
    endtask

    task automatic test_ignored_start();
        int n;
        start_pulse(8'h3C);
        n = 1;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        bg    = 8'hC3;
        start = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        n--;
        checks++;
        if (n != 385 || {done, fail} !== 2'b10) begin
            errors++;
            $display("FAIL ignstart_seq got=%0d %b exp=385 10", n, {done, fail});
        end
        checks++;
        if (mem[0] !== 8'h3C || mem[50] !== 8'h3C) begin
            errors++;
            $display("FAIL ignstart_pat got=%h/%h exp=3c", mem[0], mem[50]);
        end
    endtask

    task automatic test_rst_wins();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        bg    = 8'h11;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, fail} !== 3'b000) begin
            errors++;
            $display("FAIL rst_wins got=%b exp=000", {busy, done, fail});
        end
    endtask

    initial begin
        flip5   = 1'b0;
        stuck63 = 1'b0;
        wr_cnt  = 0;
        nw_cnt  = 0;
        test_reset();
        test_clean_pass();
        test_stuck_bit();
        test_restart();
        test_second_phase();
        test_reset_mid();
        test_ignored_start();
        test_rst_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
